div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared widths, step count and state encoding for the divider
package div_unit_pkg;

    localparam int WORD_W   = 31;   // sign-magnitude word
    localparam int MAG_W    = 30;   // magnitude: five 6-bit bytes
    localparam int BYTE_W   = 6;
    localparam int SIGN_BIT = 30;
    localparam int STEPS    = 30;   // one quotient bit per RUN cycle
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   r_in   [29:0]  partial remainder, always < vmag
//   d_bit          next dividend bit shifted in
//   vmag   [29:0]  divisor magnitude
//   r_out  [29:0]  updated partial remainder
//   q_bit          quotient bit produced by this step
module div_step
    import div_unit_pkg::*;
(
    input  logic [MAG_W-1:0] r_in,
    input  logic             d_bit,
    input  logic [MAG_W-1:0] vmag,
    output logic [MAG_W-1:0] r_out,
    output logic             q_bit
);

    logic [MAG_W:0]   t;
    logic [MAG_W-1:0] diff;

    assign t = {r_in, d_bit};

    // Because r_in < vmag, both t - vmag (when t >= vmag) and t (when
    // t < vmag) are below 2^30, so the subtraction only needs 30 bits.
    assign diff  = t[MAG_W-1:0] - vmag;
    assign q_bit = (t >= {1'b0, vmag});
    assign r_out = q_bit ? diff : t[MAG_W-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 60/30-bit sign-magnitude sequential restoring divider
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   start     request a division, taken only while busy=0
//   a   [30:0] high dividend word, sign-magnitude (sign in bit 30)
//   x   [30:0] low dividend word, only its magnitude is used
//   v   [30:0] divisor, sign-magnitude
//   busy      high while state is not IDLE
//   done      one-cycle result strobe
//   quo [30:0] quotient, sign = a.sign ^ v.sign
//   rem [30:0] remainder, sign = a.sign
//   overflow  quotient would not fit (|a| >= |v|, includes |v| = 0)
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] v,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] quo,
    output logic [WORD_W-1:0] rem,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [MAG_W-1:0] r_q;
    logic [MAG_W-1:0] q_q;
    logic [MAG_W-1:0] vmag;
    logic             a_sign;
    logic             q_sign;

    logic [MAG_W-1:0] step_r;
    logic             step_q;
    logic [MAG_W-1:0] q_next;

    div_step u_step (
        .r_in  (r_q),
        .d_bit (q_q[MAG_W-1]),
        .vmag  (vmag),
        .r_out (step_r),
        .q_bit (step_q)
    );

    // q_q holds the unconsumed low dividend bits at the top and the
    // quotient bits gathered so far at the bottom.
    assign q_next = {q_q[MAG_W-2:0], step_q};
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            vmag     <= '0;
            a_sign   <= 1'b0;
            q_sign   <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (a[MAG_W-1:0] >= v[MAG_W-1:0]) begin
                            // Operands pass through unchanged; done rises a
                            // cycle later from the FIN state.
                            quo      <= a;
                            rem      <= x;
                            overflow <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            r_q    <= a[MAG_W-1:0];
                            q_q    <= x[MAG_W-1:0];
                            vmag   <= v[MAG_W-1:0];
                            a_sign <= a[SIGN_BIT];
                            q_sign <= a[SIGN_BIT] ^ v[SIGN_BIT];
                            cnt    <= '0;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_q <= step_r;
                    q_q <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        quo      <= {q_sign, q_next};
                        rem      <= {a_sign, step_r};
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    // Normal results arrive with done already set; the
                    // overflow path raises it here for its single cycle.
                    if (done) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with random operands
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [30:0] a, x, v;
    logic        busy, done, overflow;
    logic [30:0] quo, rem;

    always #5 clk = ~clk;

    div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .x        (x),
        .v        (v),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .overflow (overflow)
    );

    typedef struct {
        logic [30:0] quo;
        logic [30:0] rem;
        logic        ovf;
        int          lat;
        int          cyc_e;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 60-bit integer division; overflow means the quotient
    // cannot be represented in 30 bits (or the divisor is zero).
    function automatic exp_t model(input logic [30:0] ia, input logic [30:0] ix, input logic [30:0] iv);
        exp_t        e;
        logic [63:0] dvd;
        logic [63:0] dvs;
        logic [63:0] q;
        logic [63:0] r;
        dvd = {4'b0, ia[29:0], ix[29:0]};
        dvs = {34'b0, iv[29:0]};
        e.cyc_e = 0;
        if (dvs == 0 || (dvd / dvs) >= (64'd1 << 30)) begin
            e.quo = ia;
            e.rem = ix;
            e.ovf = 1'b1;
            e.lat = 1;
        end else begin
            q = dvd / dvs;
            r = dvd % dvs;
            e.quo = {ia[30] ^ iv[30], q[29:0]};
            e.rem = {ia[30], r[29:0]};
            e.ovf = 1'b0;
            e.lat = 30;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [30:0] q, input logic [30:0] r, input logic o, input int l);
        exp_t e;
        e.quo = q; e.rem = r; e.ovf = o; e.lat = l; e.cyc_e = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quo", {33'b0, quo}, {33'b0, e.quo});
                check("rem", {33'b0, rem}, {33'b0, e.rem});
                check("overflow", {63'b0, overflow}, {63'b0, e.ovf});
                check("latency", 64'(cyc - e.cyc_e), 64'(e.lat));
            end
        end
    end

    // Called at a negedge: present one request, record its start edge.
    task automatic issue(input logic [30:0] ia, input logic [30:0] ix, input logic [30:0] iv, input exp_t e);
        a = ia; x = ix; v = iv; start = 1'b1;
        @(posedge clk);
        #1;
        e.cyc_e = cyc;
        sb.push_back(e);
        start = 1'b0;
    endtask

    // Wait for the scoreboard to drain, poking start with junk while busy.
    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1;
                a = 31'($urandom); x = 31'($urandom); v = 31'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            check("timeout", 1, 0);
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic run_op(input logic [30:0] ia, input logic [30:0] ix, input logic [30:0] iv, input exp_t e);
        issue(ia, ix, iv, e);
        wait_done();
    endtask

    initial begin
        logic [29:0] vm, am;
        logic [30:0] ra, rx, rv;
        int          mode;

        rst_n = 1'b0; start = 1'b0; a = '0; x = '0; v = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_done", {63'b0, done}, 0);
        check("rst_quo", {33'b0, quo}, 0);
        check("rst_rem", {33'b0, rem}, 0);
        check("rst_ovf", {63'b0, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(31'd0, 31'd17, 31'd5, mk(31'd3, 31'd2, 1'b0, 30));
        run_op(31'h4000_0000, 31'h4000_0007, 31'd2, mk(31'h4000_0003, 31'h4000_0001, 1'b0, 30));
        run_op(31'd0, 31'd100, 31'h4000_000A, mk(31'h4000_000A, 31'd0, 1'b0, 30));
        run_op(31'd1, 31'd0, 31'd2, mk(31'h2000_0000, 31'd0, 1'b0, 30));
        run_op(31'd5, 31'd9, 31'd0, mk(31'd5, 31'd9, 1'b1, 1));

        // Reset during the 10th RUN cycle abandons the operation.
        a = 31'd0; x = 31'd17; v = 31'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_running", {63'b0, busy}, 1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {63'b0, busy}, 0);
        check("midrst_done", {63'b0, done}, 0);
        check("midrst_quo", {33'b0, quo}, 0);
        check("midrst_rem", {33'b0, rem}, 0);
        check("midrst_ovf", {63'b0, overflow}, 0);
        rst_n = 1'b1;
        run_op(31'd0, 31'd17, 31'd5, mk(31'd3, 31'd2, 1'b0, 30));

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                vm = 30'($urandom_range(0, 3));
                am = 30'($urandom);
            end else begin
                vm = ($urandom_range(0, 1) == 1) ? 30'($urandom) : 30'($urandom_range(1, 1000));
                if (vm == 0) vm = 30'd1;
                am = (mode == 1) ? 30'd0 : 30'($urandom % vm);
            end
            ra = {1'($urandom), am};
            rv = {1'($urandom), vm};
            rx = 31'($urandom);
            run_op(ra, rx, rv, model(ra, rx, rv));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
